// File: rtl/fp_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_pkg
//  Description : Shared constants and types for the floating-point adder
//                front end: operand record and the aligned-pair record that
//                the alignment stage hands to the barrel shifter.
//  Contents    : EXP_W, MANT_W, SHIFT_W, MAX_SHIFT, fp_operand_t,
//                fp_align_t, low_mask()
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_add_pkg;

    localparam int EXP_W     = 4;
    localparam int MANT_W    = 8;   // hidden bit explicit at MSB; shifter is 8 bits wide
    localparam int SHIFT_W   = 3;
    localparam int MAX_SHIFT = (2 ** SHIFT_W) - 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_operand_t;

    typedef struct packed {
        logic               big_sign;
        logic [EXP_W-1:0]   big_exp;
        logic [MANT_W-1:0]  big_mant;
        logic               small_sign;
        logic [MANT_W-1:0]  small_mant;
        logic [SHIFT_W-1:0] shift_amt;
        logic               shift_ovf;
        logic               swapped;
        logic               sticky;
    } fp_align_t;

    // Mask of the n low-order significand bits, i.e. the bits a right shift
    // by n pushes out of the significand.
    function automatic logic [MANT_W-1:0] low_mask(input logic [SHIFT_W-1:0] n);
        low_mask = (MANT_W'(1) << n) - MANT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_align_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_operand_if / fp_align_if
//  Description : Handshake bundles around the alignment stage.
//                fp_operand_if : operand pair in  (in_valid/in_ready, a_*, b_*)
//                fp_align_if   : aligned pair out (out_valid/out_ready, big_*,
//                                small_*, shift_amt, shift_ovf, swapped, sticky)
//                master drives valid + payload, slave drives ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_operand_if;
    import fp_add_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              a_sign;
    logic [EXP_W-1:0]  a_exp;
    logic [MANT_W-1:0] a_mant;
    logic              b_sign;
    logic [EXP_W-1:0]  b_exp;
    logic [MANT_W-1:0] b_mant;

    modport master (
        output in_valid, a_sign, a_exp, a_mant, b_sign, b_exp, b_mant,
        input  in_ready
    );

    modport slave (
        input  in_valid, a_sign, a_exp, a_mant, b_sign, b_exp, b_mant,
        output in_ready
    );
endinterface

interface fp_align_if;
    import fp_add_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic               big_sign;
    logic [EXP_W-1:0]   big_exp;
    logic [MANT_W-1:0]  big_mant;
    logic               small_sign;
    logic [MANT_W-1:0]  small_mant;
    logic [SHIFT_W-1:0] shift_amt;
    logic               shift_ovf;
    logic               swapped;
    logic               sticky;

    modport master (
        output out_valid, big_sign, big_exp, big_mant, small_sign, small_mant,
               shift_amt, shift_ovf, swapped, sticky,
        input  out_ready
    );

    modport slave (
        input  out_valid, big_sign, big_exp, big_mant, small_sign, small_mant,
               shift_amt, shift_ovf, swapped, sticky,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fp_exp_compare.sv
`default_nettype none
// ============================================================================
//  Module      : fp_exp_compare
//  Description : Combinational magnitude ordering of two unpacked operands.
//                Produces the larger/smaller operand, the absolute exponent
//                difference and the swap flag (1 when B is strictly larger).
//  Ports       : i_a, i_b    operands
//                o_big       larger-magnitude operand (A on an exact tie)
//                o_small     smaller-magnitude operand
//                o_diff      |a_exp - b_exp|, full EXP_W bits
//                o_swap      B ordered first
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_exp_compare
    import fp_add_pkg::*;
(
    input  fp_operand_t       i_a,
    input  fp_operand_t       i_b,
    output fp_operand_t       o_big,
    output fp_operand_t       o_small,
    output logic [EXP_W-1:0]  o_diff,
    output logic              o_swap
);

    logic [EXP_W:0] w_a_minus_b;
    logic [EXP_W:0] w_b_minus_a;
    logic           w_b_exp_gt;
    logic           w_exp_eq;

    // One extra bit so the borrow tells us which exponent is larger.
    assign w_a_minus_b = {1'b0, i_a.exp} - {1'b0, i_b.exp};
    assign w_b_minus_a = {1'b0, i_b.exp} - {1'b0, i_a.exp};
    assign w_b_exp_gt  = w_a_minus_b[EXP_W];
    assign w_exp_eq    = (i_a.exp == i_b.exp);

    // Exact magnitude tie keeps A first.
    assign o_swap  = w_b_exp_gt | (w_exp_eq & (i_b.mant > i_a.mant));
    assign o_diff  = w_b_exp_gt ? w_b_minus_a[EXP_W-1:0] : w_a_minus_b[EXP_W-1:0];
    assign o_big   = o_swap ? i_b : i_a;
    assign o_small = o_swap ? i_a : i_b;

endmodule
`default_nettype wire

// File: rtl/fp_align_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fp_align_stage
//  Description : Operand-alignment front end of the FP adder. Orders two
//                operands by magnitude (S1) and derives the right-shift count,
//                shift overflow and optional sticky bit for the downstream
//                8-bit barrel shifter (S2). Two registered stages with
//                valid/ready on both sides, one pair per cycle.
//  Ports       : clk, rst  clock / synchronous active-high reset
//                in_bus    fp_operand_if.slave  (operand pair in)
//                out_bus   fp_align_if.master   (aligned pair out)
//  Options     : FP_ALIGN_STICKY_EN - when defined, sticky is the OR of the
//                small significand bits shifted out; otherwise tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_align_stage
    import fp_add_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    fp_operand_if.slave in_bus,
    fp_align_if.master  out_bus
);

    localparam logic [EXP_W-1:0]   c_max_shift_e = EXP_W'(MAX_SHIFT);
    localparam logic [SHIFT_W-1:0] c_max_shift_s = SHIFT_W'(MAX_SHIFT);

    // ---------------- handshake ----------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_adv;
    logic w_s1_adv;

    // in_ready follows out_ready combinationally so a full pipe still
    // accepts a new pair in the same cycle the output drains.
    assign w_s2_adv        = ~r_s2_valid | out_bus.out_ready;
    assign w_s1_adv        = ~r_s1_valid | w_s2_adv;
    assign in_bus.in_ready = w_s1_adv;

    // ---------------- S1: magnitude ordering ----------------
    fp_operand_t      w_a;
    fp_operand_t      w_b;
    fp_operand_t      w_big;
    fp_operand_t      w_small;
    logic [EXP_W-1:0] w_diff;
    logic             w_swap;

    assign w_a = '{sign: in_bus.a_sign, exp: in_bus.a_exp, mant: in_bus.a_mant};
    assign w_b = '{sign: in_bus.b_sign, exp: in_bus.b_exp, mant: in_bus.b_mant};

    fp_exp_compare u_cmp (
        .i_a     (w_a),
        .i_b     (w_b),
        .o_big   (w_big),
        .o_small (w_small),
        .o_diff  (w_diff),
        .o_swap  (w_swap)
    );

    fp_operand_t      r_s1_big;
    fp_operand_t      r_s1_small;
    logic [EXP_W-1:0] r_s1_diff;
    logic             r_s1_swap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_big   <= '0;
            r_s1_small <= '0;
            r_s1_diff  <= '0;
            r_s1_swap  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_bus.in_valid;
            if (in_bus.in_valid) begin
                r_s1_big   <= w_big;
                r_s1_small <= w_small;
                r_s1_diff  <= w_diff;
                r_s1_swap  <= w_swap;
            end
        end
    end

    // ---------------- S2: shift count / overflow / sticky ----------------
    logic               w_ovf;
    logic [SHIFT_W-1:0] w_shift;
    logic               w_sticky;
    fp_align_t          w_s2_next;
    fp_align_t          r_s2;

    // Overflow is judged on the full-width difference before narrowing.
    assign w_ovf   = (r_s1_diff > c_max_shift_e);
    assign w_shift = w_ovf ? c_max_shift_s : r_s1_diff[SHIFT_W-1:0];

`ifdef FP_ALIGN_STICKY_EN
    // On overflow the whole significand is shifted out.
    assign w_sticky = |(r_s1_small.mant & (w_ovf ? {MANT_W{1'b1}} : low_mask(w_shift)));
`else
    assign w_sticky = 1'b0;
`endif

    always_comb begin
        w_s2_next            = '0;
        w_s2_next.big_sign   = r_s1_big.sign;
        w_s2_next.big_exp    = r_s1_big.exp;
        w_s2_next.big_mant   = r_s1_big.mant;
        w_s2_next.small_sign = r_s1_small.sign;
        w_s2_next.small_mant = r_s1_small.mant;
        w_s2_next.shift_amt  = w_shift;
        w_s2_next.shift_ovf  = w_ovf;
        w_s2_next.swapped    = r_s1_swap;
        w_s2_next.sticky     = w_sticky;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2 <= w_s2_next;
            end
        end
    end

    // ---------------- outputs ----------------
    assign out_bus.out_valid  = r_s2_valid;
    assign out_bus.big_sign   = r_s2.big_sign;
    assign out_bus.big_exp    = r_s2.big_exp;
    assign out_bus.big_mant   = r_s2.big_mant;
    assign out_bus.small_sign = r_s2.small_sign;
    assign out_bus.small_mant = r_s2.small_mant;
    assign out_bus.shift_amt  = r_s2.shift_amt;
    assign out_bus.shift_ovf  = r_s2.shift_ovf;
    assign out_bus.swapped    = r_s2.swapped;
    assign out_bus.sticky     = r_s2.sticky;

endmodule
`default_nettype wire

// File: tb/tb_fp_align_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_align_stage
//  Description : Directed self-checking bench for fp_align_stage: reset
//                state, ordering/swap, shift overflow boundary, sticky,
//                output stall, back-to-back streaming and mid-flight reset.
//  Options     : FP_ALIGN_STICKY_EN selects the expected sticky values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_align_stage;
    import fp_add_pkg::*;

`ifdef FP_ALIGN_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fp_operand_if in_bus ();
    fp_align_if   out_bus ();

    fp_align_stage dut (
        .clk     (clk),
        .rst     (rst),
        .in_bus  (in_bus),
        .out_bus (out_bus)
    );

    always #5 clk = ~clk;

    function automatic fp_operand_t op(input logic s, input int e, input int m);
        fp_operand_t r;
        r.sign = s;
        r.exp  = EXP_W'(e);
        r.mant = MANT_W'(m);
        return r;
    endfunction

    function automatic fp_align_t get_out();
        fp_align_t r;
        r.big_sign   = out_bus.big_sign;
        r.big_exp    = out_bus.big_exp;
        r.big_mant   = out_bus.big_mant;
        r.small_sign = out_bus.small_sign;
        r.small_mant = out_bus.small_mant;
        r.shift_amt  = out_bus.shift_amt;
        r.shift_ovf  = out_bus.shift_ovf;
        r.swapped    = out_bus.swapped;
        r.sticky     = out_bus.sticky;
        return r;
    endfunction

    task automatic drive_pair(input fp_operand_t a, input fp_operand_t b, input logic v);
        in_bus.in_valid = v;
        in_bus.a_sign   = a.sign;
        in_bus.a_exp    = a.exp;
        in_bus.a_mant   = a.mant;
        in_bus.b_sign   = b.sign;
        in_bus.b_exp    = b.exp;
        in_bus.b_mant   = b.mant;
    endtask

    task automatic idle(input int n);
        drive_pair('0, '0, 1'b0);
        out_bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Present one pair on an idle pipe and wait (bounded) for its result.
    task automatic run_pair(input fp_operand_t a, input fp_operand_t b, output int lat);
        out_bus.out_ready = 1'b1;
        drive_pair(a, b, 1'b1);
        @(posedge clk); #1;
        drive_pair('0, '0, 1'b0);
        lat = 1;
        while (!out_bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        fp_align_t z;
        z = '0;
        rst = 1'b1;
        drive_pair('0, '0, 1'b0);
        out_bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (out_bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b want=0", out_bus.out_valid);
        end
        checks++;
        if (get_out() !== z) begin
            errors++; $display("FAIL reset_data got=%h want=%h", get_out(), z);
        end
        checks++;
        if (in_bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b want=1", in_bus.in_ready);
        end
    endtask

    task automatic test_order();
        fp_align_t e;
        int lat;
        run_pair(op(0, 5, 'h90), op(0, 3, 'hC0), lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL latency got=%0d want=2", lat);
        end
        e = '{1'b0, 4'd5, 8'h90, 1'b0, 8'hC0, 3'd2, 1'b0, 1'b0, 1'b0};
        checks++;
        if (get_out() !== e) begin
            errors++; $display("FAIL order_a_big got=%h want=%h", get_out(), e);
        end
        run_pair(op(1, 2, 'h80), op(0, 2, 'hA0), lat);
        e = '{1'b0, 4'd2, 8'hA0, 1'b1, 8'h80, 3'd0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (get_out() !== e) begin
            errors++; $display("FAIL order_mant_swap got=%h want=%h", get_out(), e);
        end
        run_pair(op(0, 4, 'h88), op(0, 4, 'h88), lat);
        e = '{1'b0, 4'd4, 8'h88, 1'b0, 8'h88, 3'd0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (get_out() !== e) begin
            errors++; $display("FAIL order_tie got=%h want=%h", get_out(), e);
        end
        run_pair(op(0, 1, 'hFF), op(1, 6, 'h81), lat);
        e = '{1'b1, 4'd6, 8'h81, 1'b0, 8'hFF, 3'd5, 1'b0, 1'b1, STK};
        checks++;
        if (get_out() !== e) begin
            errors++; $display("FAIL order_exp_swap got=%h want=%h", get_out(), e);
        end
        run_pair(op(0, 0, 'h00), op(0, 3, 'h80), lat);
        e = '{1'b0, 4'd3, 8'h80, 1'b0, 8'h00, 3'd3, 1'b0, 1'b1, 1'b0};
        checks++;
        if (get_out() !== e) begin
            errors++; $display("FAIL order_zero got=%h want=%h", get_out(), e);
        end
    endtask

    task automatic test_shift_ovf();
        fp_align_t e;
        int lat;
        run_pair(op(0, 15, 'h80), op(0, 1, 'hFF), lat);
        e = '{1'b0, 4'd15, 8'h80, 1'b0, 8'hFF, 3'd7, 1'b1, 1'b0, STK};
        checks++;
        if (get_out() !== e) begin
            errors++; $display("FAIL ovf_d14 got=%h want=%h", get_out(), e);
        end
        run_pair(op(0, 8, 'h80), op(0, 1, 'hFF), lat);
        e = '{1'b0, 4'd8, 8'h80, 1'b0, 8'hFF, 3'd7, 1'b0, 1'b0, STK};
        checks++;
        if (get_out() !== e) begin
            errors++; $display("FAIL ovf_d7 got=%h want=%h", get_out(), e);
        end
        run_pair(op(0, 9, 'h80), op(0, 1, 'hFF), lat);
        e = '{1'b0, 4'd9, 8'h80, 1'b0, 8'hFF, 3'd7, 1'b1, 1'b0, STK};
        checks++;
        if (get_out() !== e) begin
            errors++; $display("FAIL ovf_d8 got=%h want=%h", get_out(), e);
        end
    endtask

    task automatic test_sticky();
        fp_align_t e;
        int lat;
        run_pair(op(0, 4, 'h80), op(0, 1, 'h80), lat);
        e = '{1'b0, 4'd4, 8'h80, 1'b0, 8'h80, 3'd3, 1'b0, 1'b0, 1'b0};
        checks++;
        if (get_out() !== e) begin
            errors++; $display("FAIL sticky_clear got=%h want=%h", get_out(), e);
        end
        run_pair(op(0, 4, 'h80), op(0, 1, 'h84), lat);
        e = '{1'b0, 4'd4, 8'h80, 1'b0, 8'h84, 3'd3, 1'b0, 1'b0, STK};
        checks++;
        if (get_out() !== e) begin
            errors++; $display("FAIL sticky_set got=%h want=%h", get_out(), e);
        end
    endtask

    // Four pairs with the output stalled for the first six cycles.
    task automatic test_stall();
        int n_in = 0;
        int n_out = 0;
        logic acc;
        logic saw_stall = 1'b0;
        logic held_v = 1'b0;
        logic [MANT_W-1:0] held = '0;
        idle(2);
        for (int cyc = 0; cyc < 40 && n_out < 4; cyc++) begin
            out_bus.out_ready = (cyc >= 6);
            drive_pair(op(0, 8, 'h81 + n_in), op(0, 2, 'h90), n_in < 4);
            #1;
            acc = in_bus.in_valid & in_bus.in_ready;
            if (!in_bus.in_ready) saw_stall = 1'b1;
            if (out_bus.out_valid && !out_bus.out_ready) begin
                if (held_v) begin
                    checks++;
                    if (out_bus.big_mant !== held) begin
                        errors++; $display("FAIL stall_hold got=%h want=%h", out_bus.big_mant, held);
                    end
                end
                held   = out_bus.big_mant;
                held_v = 1'b1;
            end
            if (out_bus.out_valid && out_bus.out_ready) begin
                checks++;
                if (out_bus.big_mant !== MANT_W'('h81 + n_out)) begin
                    errors++; $display("FAIL stall_order got=%h want=%h", out_bus.big_mant, MANT_W'('h81 + n_out));
                end
                n_out++;
            end
            @(posedge clk); #1;
            if (acc) n_in++;
        end
        checks++;
        if (saw_stall !== 1'b1) begin
            errors++; $display("FAIL stall_in_ready got=%b want=1", saw_stall);
        end
        checks++;
        if (n_out !== 4) begin
            errors++; $display("FAIL stall_count got=%0d want=4", n_out);
        end
        idle(3);
        checks++;
        if (out_bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_dup got=%b want=0", out_bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n_out = 0;
        idle(2);
        for (int cyc = 0; cyc < 10; cyc++) begin
            out_bus.out_ready = 1'b1;
            drive_pair(op(0, 7, 'hA0 + cyc), op(0, 6, 'h80), cyc < 6);
            #1;
            if (cyc < 6) begin
                checks++;
                if (in_bus.in_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, in_bus.in_ready);
                end
            end
            if (cyc >= 2 && cyc < 8) begin
                checks++;
                if (out_bus.out_valid !== 1'b1) begin
                    errors++; $display("FAIL b2b_out_valid cyc=%0d got=%b want=1", cyc, out_bus.out_valid);
                end
            end
            if (out_bus.out_valid) begin
                checks++;
                if (out_bus.big_mant !== MANT_W'('hA0 + n_out)) begin
                    errors++; $display("FAIL b2b_order got=%h want=%h", out_bus.big_mant, MANT_W'('hA0 + n_out));
                end
                n_out++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (n_out !== 6) begin
            errors++; $display("FAIL b2b_count got=%0d want=6", n_out);
        end
    endtask

    task automatic test_reset_midflight();
        fp_align_t z;
        z = '0;
        idle(2);
        drive_pair(op(0, 9, 'hC1), op(0, 2, 'h80), 1'b1);
        @(posedge clk); #1;
        drive_pair(op(0, 9, 'hC2), op(0, 2, 'h80), 1'b1);
        @(posedge clk); #1;
        drive_pair('0, '0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_out_valid got=%b want=0", out_bus.out_valid);
        end
        checks++;
        if (get_out() !== z) begin
            errors++; $display("FAIL midrst_data got=%h want=%h", get_out(), z);
        end
        checks++;
        if (in_bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_in_ready got=%b want=1", in_bus.in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_ghost cyc=%0d got=%b want=0", i, out_bus.out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_shift_ovf();
        test_sticky();
        test_stall();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_align_stage.md
Name: fp_align_stage

Overview:
- Operand-alignment front end of the floating-point adder. Sits directly upstream of the 8-bit right barrel shifter.
- Takes two unpacked operands and orders them by magnitude (larger first).
- Emits the smaller significand, a 3-bit right-shift count and a shift-overflow flag for the shifter, plus the larger operand for the mantissa adder.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 4, exponent width (biased, unsigned).
- MANT_W, 8, significand width, hidden bit explicit at MSB. Fixed at 8 to match the shifter.
- SHIFT_W, 3, shift-count width; maximum encodable shift is 2^SHIFT_W-1 = 7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input operand pair valid.
- in_ready  out  1  stage can accept an operand pair.
- a_sign  in  1  operand A sign.
- a_exp  in  EXP_W  operand A exponent.
- a_mant  in  MANT_W  operand A significand.
- b_sign  in  1  operand B sign.
- b_exp  in  EXP_W  operand B exponent.
- b_mant  in  MANT_W  operand B significand.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts result.
- big_sign  out  1  sign of larger-magnitude operand.
- big_exp  out  EXP_W  exponent of larger operand; this is the result exponent before normalisation.
- big_mant  out  MANT_W  significand of larger operand.
- small_sign  out  1  sign of smaller operand.
- small_mant  out  MANT_W  unshifted significand of smaller operand; feeds shifter data input.
- shift_amt  out  SHIFT_W  right-shift count; feeds shifter k.
- shift_ovf  out  1  exponent difference > 7; downstream forces aligned small significand to 0.
- swapped  out  1  1 when B was larger and the operands were exchanged.
- sticky  out  1  OR of bits shifted out of small_mant (see Optional Feature).

Behaviour:
- Reset: synchronous, active-high.
  - On a clk edge with rst=1: both stage valid flags clear, so out_valid=0.
  - All data outputs go to 0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards both in-flight pairs; nothing is emitted for them.
- Stage 1 (S1), registered:
  - exponent difference d = |a_exp - b_exp|, computed as EXP_W+1-bit subtract.
  - Swap decision:
    - swap=1 if b_exp > a_exp;
    - or if exponents are equal and b_mant > a_mant;
    - exact magnitude tie gives swap=0.
  - S1 latches the ordered operands, d and swap.
- Stage 2 (S2), registered:
  - shift_amt = d[SHIFT_W-1:0] if d <= 7; otherwise shift_amt = 7 and shift_ovf=1.
  - S2 latches all outputs.
- Latency: exactly 2 cycles from handshake (in_valid & in_ready) to out_valid when out_ready stays high. Throughput is 1 pair per cycle.
- Handshake:
  - Transfer occurs on valid & ready at a clk edge.
  - S2 advances when !s2_valid | out_ready.
  - S1 advances when !s1_valid | S2 advances.
  - in_ready = !s1_valid | S2 advances. This is combinational from out_ready; no bubble is inserted.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - Simultaneous input accept and output drain in the same cycle is legal and must not lose or duplicate data.
- Zero operands: no special case. Significand 0 with exponent 0 orders as smallest.
- Width rule: exponent difference is never truncated before the overflow check.

Optional Feature:
- Macro FP_ALIGN_STICKY_EN.
- Defined: S2 computes sticky as the OR of small_mant bits [shift_amt-1:0]. If shift_ovf=1, sticky = OR of all small_mant bits. sticky is registered with the other S2 outputs.
- Undefined: sticky is tied to 0, and no sticky logic is synthesised.
- Port list is identical in both builds.

Decomposition:
- Package fp_add_pkg holds:
  - EXP_W, MANT_W, SHIFT_W constants;
  - typedef fp_operand_t {sign, exp, mant};
  - typedef fp_align_t (all S2 outputs).
- One natural sub-module: fp_exp_compare, a combinational block producing swap, d and the ordered operands, instantiated in S1.

Test Plan:
- a=(0,5,0x90), b=(0,3,0xC0), out_ready=1 -> after 2 cycles: big_exp=5, big_mant=0x90, small_mant=0xC0, shift_amt=2, swapped=0, shift_ovf=0.
- a=(1,2,0x80), b=(0,2,0xA0) -> swapped=1, big_sign=0, big_mant=0xA0, shift_amt=0. Equal-magnitude pair a=b=(0,4,0x88) -> swapped=0.
- a=(0,15,0x80), b=(0,1,0xFF) -> shift_amt=7, shift_ovf=1. With FP_ALIGN_STICKY_EN: sticky=1. b_mant=0x80, d=3 -> sticky=0; b_mant=0x84, d=3 -> sticky=1.
- Stream 4 pairs with out_ready low for cycles 3-6 -> in_ready drops once S1 and S2 are full; outputs hold; all 4 results emerge in order with no loss or duplication.
- Back-to-back accept with continuous out_ready=1 -> one result per cycle, in_ready never deasserts.
- Assert rst for 1 cycle with 2 pairs in flight -> next cycle out_valid=0, outputs 0, in_ready=1; in-flight pairs never appear.
